// File: rtl/usb_rx_packet.sv
// usb_rx_packet: decodes link bytes into USB packets; CRC checking built only with USB_RX_CRC_CHECK_EN
module usb_rx_packet #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        CLK_60M,
  input  logic        NRST_A_USB,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STRB,
  input  logic        RX_END,
  input  logic        RX_FAIL,
  output logic [3:0]  PKT_PID,
  output logic        PKT_VALID,
  output logic        PKT_ERR,
  output logic [2:0]  ERR_CODE,
  output logic [6:0]  TOK_ADDR,
  output logic [3:0]  TOK_ENDP,
  output logic [10:0] FRAME_NUM,
  output logic [7:0]  DATA_O,
  output logic        DATA_STRB,
  output logic [9:0]  DATA_LEN
);
  typedef enum logic [2:0] {IDLE, TOKEN, DATA, HSK, DISCARD, REPORT} state_t;
  localparam logic [10:0] LIM = 11'(MAX_PAYLOAD + 1);
  state_t state, nxt, s1;
  logic [2:0] pend, pend_nxt, err_fin;
  logic [10:0] cnt, n;
  logic [15:0] tok;
  logic [7:0] hold0, hold1;
  logic [3:0] pid;
  logic strb, fin, fail, pid_ok, emit, crc_bad, active;
  // a link fail masks any byte or end arriving in the same cycle
  assign fail = RX_FAIL;
  assign strb = RX_STRB & ~RX_FAIL;
  assign fin = RX_END & ~RX_FAIL;
  assign pid_ok = RX_DATA[7:4] == ~RX_DATA[3:0];
  assign n = cnt + {10'd0, strb};
  assign active = state != IDLE && state != REPORT;
  always_ff @(posedge CLK_60M or negedge NRST_A_USB)
    if (!NRST_A_USB) begin
      state <= IDLE;
      pend <= 3'd0;
    end else begin
      state <= nxt;
      pend <= pend_nxt;
    end
  always_comb begin
    nxt = state;
    pend_nxt = pend;
    s1 = (!pid_ok || RX_DATA[1:0] == 2'b00) ? DISCARD :
         RX_DATA[1:0] == 2'b01 ? TOKEN : RX_DATA[1:0] == 2'b11 ? DATA : HSK;
    if (fail && active) begin
      nxt = REPORT;
      pend_nxt = 3'd4;
    end else begin
      case (state)
        IDLE: if (strb) begin
          nxt = fin ? REPORT : s1;
          pend_nxt = !pid_ok ? 3'd1 :
                     (RX_DATA[1:0] == 2'b00 || (fin && (s1 == TOKEN || s1 == DATA))) ? 3'd3 : 3'd0;
        end
        TOKEN: if (fin) begin
          nxt = REPORT;
          pend_nxt = n == 11'd2 ? 3'd0 : 3'd3;
        end else if (strb && cnt == 11'd2) begin
          nxt = DISCARD;
          pend_nxt = 3'd3;
        end
        DATA: begin
          if (strb && cnt > LIM) begin
            nxt = DISCARD;
            pend_nxt = 3'd3;
          end
          if (fin) begin
            nxt = REPORT;
            if (n < 11'd2) pend_nxt = 3'd3;
          end
        end
        HSK: if (strb) begin
          nxt = fin ? REPORT : DISCARD;
          pend_nxt = 3'd3;
        end else if (fin) nxt = REPORT;
        DISCARD: if (fin) nxt = REPORT;
        default: nxt = IDLE;
      endcase
    end
  end
  always_comb begin
    emit = state == DATA && strb && cnt >= 11'd2 && cnt <= LIM;
    err_fin = pend != 3'd0 ? pend : crc_bad ? 3'd2 : 3'd0;
  end
`ifdef USB_RX_CRC_CHECK_EN
  logic [15:0] crc16;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction
  function automatic logic [4:0] crc5(input logic [15:0] d);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 16; i++) r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction
  always_ff @(posedge CLK_60M or negedge NRST_A_USB)
    if (!NRST_A_USB) crc16 <= 16'hFFFF;
    else if (state == IDLE && strb) crc16 <= 16'hFFFF;
    else if (state == DATA && strb) crc16 <= crc16_byte(crc16, RX_DATA);
  assign crc_bad = pid[1:0] == 2'b01 ? crc5(tok) != 5'b01100 :
                   pid[1:0] == 2'b11 ? crc16 != 16'h800D : 1'b0;
`else
  logic unused_crc;
  assign unused_crc = ^tok[15:11];
  assign crc_bad = 1'b0;
`endif
  always_ff @(posedge CLK_60M or negedge NRST_A_USB)
    if (!NRST_A_USB) begin
      PKT_PID <= 4'd0;
      PKT_VALID <= 1'b0;
      PKT_ERR <= 1'b0;
      ERR_CODE <= 3'd0;
      TOK_ADDR <= 7'd0;
      TOK_ENDP <= 4'd0;
      FRAME_NUM <= 11'd0;
      DATA_O <= 8'd0;
      DATA_STRB <= 1'b0;
      DATA_LEN <= 10'd0;
      pid <= 4'd0;
      cnt <= 11'd0;
      tok <= 16'd0;
      hold0 <= 8'd0;
      hold1 <= 8'd0;
    end else begin
      PKT_VALID <= state == REPORT && err_fin == 3'd0;
      PKT_ERR <= state == REPORT && err_fin != 3'd0;
      DATA_STRB <= emit;
      if (emit) begin
        DATA_O <= hold0;
        DATA_LEN <= DATA_LEN + 10'd1;
      end
      if (state == IDLE && strb) begin
        pid <= RX_DATA[3:0];
        cnt <= 11'd0;
        DATA_LEN <= 10'd0;
      end
      // the last two bytes seen are always held back as a potential CRC
      if (strb && (state == TOKEN || state == DATA)) begin
        cnt <= n;
        tok <= {RX_DATA, tok[15:8]};
        hold0 <= hold1;
        hold1 <= RX_DATA;
      end
      if (state == REPORT) begin
        PKT_PID <= pid;
        ERR_CODE <= err_fin;
        if (pid[1:0] == 2'b01) begin
          TOK_ADDR <= tok[6:0];
          TOK_ENDP <= tok[10:7];
          FRAME_NUM <= tok[10:0];
        end
      end
    end
endmodule

// File: tb/tb_usb_rx_packet.sv
// tb_usb_rx_packet: directed checks of usb_rx_packet, main instance plus a MAX_PAYLOAD=4 instance
module tb_usb_rx_packet;
  logic clk = 1'b0, nrst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_strb = 1'b0, rx_end = 1'b0, rx_fail = 1'b0;
  logic [3:0] pkt_pid, pkt_pid_4, tok_endp, tok_endp_4;
  logic pkt_valid, pkt_err, data_strb, pkt_valid_4, pkt_err_4, data_strb_4;
  logic [2:0] err_code, err_code_4;
  logic [6:0] tok_addr, tok_addr_4;
  logic [10:0] frame_num, frame_num_4;
  logic [7:0] data_o, data_o_4;
  logic [9:0] data_len, data_len_4;
  int checks = 0, errors = 0;
  int nv = 0, ne = 0, ns4 = 0, ne4 = 0;
  logic [7:0] dq[$];
  logic [63:0] got;
  usb_rx_packet dut (
    .CLK_60M(clk), .NRST_A_USB(nrst), .RX_DATA(rx_data), .RX_STRB(rx_strb), .RX_END(rx_end),
    .RX_FAIL(rx_fail), .PKT_PID(pkt_pid), .PKT_VALID(pkt_valid), .PKT_ERR(pkt_err),
    .ERR_CODE(err_code), .TOK_ADDR(tok_addr), .TOK_ENDP(tok_endp), .FRAME_NUM(frame_num),
    .DATA_O(data_o), .DATA_STRB(data_strb), .DATA_LEN(data_len)
  );
  usb_rx_packet #(.MAX_PAYLOAD(4)) dut4 (
    .CLK_60M(clk), .NRST_A_USB(nrst), .RX_DATA(rx_data), .RX_STRB(rx_strb), .RX_END(rx_end),
    .RX_FAIL(rx_fail), .PKT_PID(pkt_pid_4), .PKT_VALID(pkt_valid_4), .PKT_ERR(pkt_err_4),
    .ERR_CODE(err_code_4), .TOK_ADDR(tok_addr_4), .TOK_ENDP(tok_endp_4), .FRAME_NUM(frame_num_4),
    .DATA_O(data_o_4), .DATA_STRB(data_strb_4), .DATA_LEN(data_len_4)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (data_strb) dq.push_back(data_o);
    if (pkt_valid) nv++;
    if (pkt_err) ne++;
    if (data_strb_4) ns4++;
    if (pkt_err_4) ne4++;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_strb = 1'b1;
    tick();
    rx_strb = 1'b0;
  endtask
  task automatic send_end(input logic [7:0] b);
    rx_data = b;
    rx_strb = 1'b1;
    rx_end = 1'b1;
    tick();
    rx_strb = 1'b0;
    rx_end = 1'b0;
  endtask
  task automatic fin();
    rx_end = 1'b1;
    tick();
    rx_end = 1'b0;
  endtask
  task automatic abort();
    rx_fail = 1'b1;
    tick();
    rx_fail = 1'b0;
  endtask
  task automatic settle();
    repeat (3) tick();
  endtask
  task automatic clr();
    dq.delete();
    nv = 0;
    ne = 0;
    ns4 = 0;
    ne4 = 0;
  endtask
  task automatic expect_report(input string tag, input int v, input int e, input logic [2:0] code);
    check({tag, "_valid"}, 64'(nv), 64'(v));
    check({tag, "_err"}, 64'(ne), 64'(e));
    check({tag, "_code"}, 64'(err_code), 64'(code));
  endtask
  initial begin
    repeat (2) tick();
    check("reset_outputs", {pkt_pid, pkt_valid, pkt_err, err_code, tok_addr, tok_endp, frame_num,
                            data_o, data_strb, data_len}, 64'd0);
    nrst = 1'b1;
    tick();
    clr();
    // SETUP token with report latency
    send(8'h2D); send(8'h00); send(8'h10); fin();
    check("setup_not_early", 64'(pkt_valid), 64'd0);
    tick();
    check("setup_valid_pulse", {pkt_valid, pkt_err}, 64'b10);
    tick();
    check("setup_valid_one_cycle", 64'(pkt_valid), 64'd0);
    check("setup_fields", {pkt_pid, tok_addr, tok_endp}, {4'hD, 7'd0, 4'd0});
    settle();
    check("setup_count", 64'(nv), 64'd1);
    clr();
    // OUT token addr 1 endp 1
    send(8'hE1); send(8'h81); send(8'h58); fin(); settle();
    expect_report("out_tok", 1, 0, 3'd0);
    check("out_fields", {pkt_pid, tok_addr, tok_endp, frame_num}, {4'h1, 7'd1, 4'd1, 11'h081});
    clr();
    send(8'hE1); send(8'h81); send(8'h59); fin(); settle();
`ifdef USB_RX_CRC_CHECK_EN
    expect_report("tok_badcrc", 0, 1, 3'd2);
`else
    expect_report("tok_badcrc", 1, 0, 3'd0);
`endif
    clr();
    // DATA0 setup payload with per-byte latency
    send(8'hC3); send(8'h80); send(8'h06);
    check("data_no_strb_early", 64'(data_strb), 64'd0);
    send(8'h00);
    check("data_strb_latency", {data_strb, data_o}, {1'b1, 8'h80});
    send(8'h01); send(8'h00); send(8'h00); send(8'h40); send(8'h00); send(8'hDD); send(8'h94);
    fin(); settle();
    check("data0_count", 64'(dq.size()), 64'd8);
    got = 64'd0;
    foreach (dq[i]) got = {got[55:0], dq[i]};
    check("data0_bytes", got, 64'h8006000100004000);
    check("data0_len", 64'(data_len), 64'd8);
    expect_report("data0", 1, 0, 3'd0);
    check("data0_pid", 64'(pkt_pid), 64'h3);
    clr();
    send(8'hC3); send(8'h80); send(8'h06); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
    send(8'h40); send(8'h00); send(8'hDD); send(8'h95); fin(); settle();
    check("data0_bad_count", 64'(dq.size()), 64'd8);
`ifdef USB_RX_CRC_CHECK_EN
    expect_report("data0_badcrc", 0, 1, 3'd2);
`else
    expect_report("data0_badcrc", 1, 0, 3'd0);
`endif
    clr();
    send(8'h4B); send(8'h00); send(8'h00); fin(); settle();
    check("zlp_count", 64'(dq.size()), 64'd0);
    check("zlp_len", 64'(data_len), 64'd0);
    expect_report("zlp", 1, 0, 3'd0);
    clr();
    send(8'hD2); fin(); settle();
    expect_report("ack", 1, 0, 3'd0);
    check("ack_pid", 64'(pkt_pid), 64'h2);
    clr();
    send(8'hD3); fin(); settle();
    expect_report("bad_pid", 0, 1, 3'd1);
    check("bad_pid_pid", 64'(pkt_pid), 64'h3);
    clr();
    send(8'h69); send(8'h00); abort(); settle();
    expect_report("in_fail", 0, 1, 3'd4);
    clr();
    // payload length limit on the MAX_PAYLOAD=4 instance
    send(8'hC3); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(8'hAA); send(8'hBB); fin(); settle();
    check("ovf_strobes", 64'(ns4), 64'd4);
    check("ovf_err", {32'(ne4), 29'd0, err_code_4}, {32'd1, 29'd0, 3'd3});
    clr();
    send(8'h2D); send(8'h00); fin(); settle();
    expect_report("tok_short", 0, 1, 3'd3);
    clr();
    send(8'h2D); send(8'h00); send(8'h10); send(8'h00); fin(); settle();
    expect_report("tok_long", 0, 1, 3'd3);
    clr();
    send(8'hC3); send(8'h00); fin(); settle();
    expect_report("data_short", 0, 1, 3'd3);
    clr();
    send(8'hD2); send(8'h00); fin(); settle();
    expect_report("hsk_extra", 0, 1, 3'd3);
    clr();
    send(8'h3C); send(8'h00); fin(); settle();
    expect_report("special", 0, 1, 3'd3);
    clr();
    send(8'hD3); send(8'h00); abort(); settle();
    expect_report("fail_overrides", 0, 1, 3'd4);
    clr();
    // simultaneous strobe and end; fail while idle is ignored
    abort(); send(8'h2D); send(8'h00); send_end(8'h10); settle();
    expect_report("strb_end_tok", 1, 0, 3'd0);
    clr();
    send_end(8'hD2); settle();
    expect_report("strb_end_ack", 1, 0, 3'd0);
    clr();
    send(8'hD2); fin(); tick(); send(8'h5A); fin(); settle();
    expect_report("back_to_back", 2, 0, 3'd0);
    check("b2b_pid", 64'(pkt_pid), 64'hA);
    clr();
    send(8'hD2); fin(); send(8'h5A); fin(); settle();
    expect_report("pid_in_report_lost", 1, 0, 3'd0);
    check("lost_pid", 64'(pkt_pid), 64'h2);
    clr();
    send(8'hC3); send(8'h80); send(8'h06);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    send(8'h69); send(8'h00); send(8'h10); fin(); settle();
    expect_report("after_reset", 1, 0, 3'd0);
    check("after_reset_pid", 64'(pkt_pid), 64'h9);
    check("after_reset_nodata", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
